z_sample_buffer: RTL
====================

Z_SAMPLE_BUFFER -- requirements
Module: z_sample_buffer

Interface
REQ-001 SHALL have parameter DW, default 26, bit width of one signed sample.
REQ-002 SHALL have parameter DEPTH, default 128, samples per channel, power of two, 2..4096.
REQ-003 SHALL have parameter NCH, default 4, channel count, 1..8.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port go  input  1  enable; low forces IDLE.
REQ-007 SHALL have port rw  input  1  mode: 1 = write, 0 = read.
REQ-008 SHALL have port in_valid  input  1  write strobe; z_in accepted when high in WRITE.
REQ-009 SHALL have port z_in  input  NCH*DW  packed samples, channel 0 in LSBs.
REQ-010 SHALL have port z_out  output  NCH*DW  registered output samples, same packing.
REQ-011 SHALL have port out_valid  output  1  z_out holds a valid sample set this cycle.
REQ-012 SHALL have port fill  output  log2(DEPTH)+1  number of stored sample sets.
REQ-013 SHALL have port full  output  1  fill == DEPTH.
REQ-014 SHALL have port wr_done  output  1  one-cycle pulse when fill reaches DEPTH.
REQ-015 SHALL have port rd_done  output  1  one-cycle pulse when the last stored set is output.
REQ-016 SHALL have port pass_cnt  output  8  completed read passes, saturating at 255.

Function
REQ-017 SHALL implement states IDLE, WRITE, READ, HOLD; go=0 -> IDLE from any state in the next cycle; in IDLE, pointer=0 and out_valid=0.
REQ-018 SHALL enter WRITE from IDLE when go=1,rw=1, and READ when go=1,rw=0; a change of rw while go=1 SHALL reset the pointer to 0 and switch state in that cycle, without issuing any output for that cycle.
REQ-019 On entry to WRITE, fill SHALL clear to 0; each cycle with in_valid=1 and fill<DEPTH stores z_in at pointer, increments pointer and fill, and echoes z_in on z_out with out_valid=1 one cycle later.
REQ-020 With fill==DEPTH, WRITE SHALL ignore in_valid (no overwrite, no echo, out_valid=0).
REQ-021 wr_done SHALL pulse in the cycle after the write that makes fill==DEPTH.
REQ-022 READ SHALL output mem[pointer] on z_out with out_valid=1 one cycle after each READ cycle, advancing pointer every cycle, over entries 0..fill-1 only.
REQ-023 READ with fill==0 SHALL keep out_valid=0 and never pulse rd_done.
REQ-024 rd_done SHALL pulse coincident with out_valid for entry fill-1; pass_cnt increments in the same cycle, saturating at 255, and clears on entry to WRITE.
REQ-025 fill, full and stored data SHALL persist across IDLE; only WRITE entry clears fill.
REQ-026 Each channel SHALL be stored and returned bit-exact; there SHALL be no arithmetic on the data path.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, pointer=0, fill=0, full=0, z_out=0, out_valid=0, wr_done=0, rd_done=0, pass_cnt=0.
REQ-028 Memory contents SHALL NOT be reset; reset during WRITE SHALL discard the partial fill (fill=0).
REQ-029 The first rising edge after rst_n deasserts SHALL be treated as a normal cycle.

Configuration
REQ-030 With macro ZBUF_WRAP_EN defined, READ SHALL wrap pointer from fill-1 to 0 and continue streaming indefinitely, pulsing rd_done once per pass.
REQ-031 Without ZBUF_WRAP_EN, READ SHALL move to HOLD after entry fill-1; HOLD keeps out_valid=0 until go=0 or rw changes, so pass_cnt never exceeds 1 per READ entry.

Verification
REQ-032 Reset, then go=1,rw=1, in_valid=1 for 128 cycles with channel c of sample k = k*4+c -> fill=128, full=1, wr_done pulses once, echoes match one cycle later.
REQ-033 After REQ-032, go=1,rw=0 -> 128 consecutive out_valid cycles returning values 0..511 in order, rd_done with sample 127; without wrap -> HOLD with out_valid=0; with wrap -> sample 0 follows and pass_cnt=2 after 256 outputs.
REQ-034 Write 5 sets (in_valid gapped every other cycle), then read -> exactly 5 outputs per pass, rd_done on the 5th.
REQ-035 After a full write, in_valid=1 for 3 more cycles -> no out_valid, memory unchanged; go=0 then read -> original data.
REQ-036 Assert rst_n=0 mid-READ at sample 40 -> all outputs zero the same cycle, fill=0; a subsequent read gives no out_valid.

Source files
------------

// File: rtl/z_sample_buffer_if.sv
// z_sample_buffer_if
//   Bundles the control, sample and status signals of z_sample_buffer.
//   master : drives go/rw/in_valid/z_in, observes the buffer outputs.
//   slave  : the buffer itself.
//   Signals:
//     go        enable, low returns the buffer to IDLE
//     rw        1 = write mode, 0 = read mode
//     in_valid  write strobe for z_in
//     z_in      NCH packed signed samples, channel 0 in LSBs
//     z_out     registered output samples, same packing
//     out_valid z_out carries a valid sample set
//     fill      number of stored sample sets
//     full      fill == DEPTH
//     wr_done   one-cycle pulse when the buffer becomes full
//     rd_done   one-cycle pulse with the last stored set of a pass
//     pass_cnt  completed read passes, saturating at 255
interface z_sample_buffer_if #(
  parameter int unsigned DW    = 26,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned NCH   = 4
);
  logic                       go;
  logic                       rw;
  logic                       in_valid;
  logic [NCH*DW-1:0]          z_in;
  logic [NCH*DW-1:0]          z_out;
  logic                       out_valid;
  logic [$clog2(DEPTH):0]     fill;
  logic                       full;
  logic                       wr_done;
  logic                       rd_done;
  logic [7:0]                 pass_cnt;

  modport master (
    output go, rw, in_valid, z_in,
    input  z_out, out_valid, fill, full, wr_done, rd_done, pass_cnt
  );

  modport slave (
    input  go, rw, in_valid, z_in,
    output z_out, out_valid, fill, full, wr_done, rd_done, pass_cnt
  );
endinterface

// File: rtl/z_sample_buffer.sv
// z_sample_buffer
//   Multi-channel sample capture/playback buffer. In WRITE it stores sample
//   sets and echoes them one cycle later; in READ it plays back the stored
//   sets 0..fill-1 in order. Data passes through bit-exact.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    z_sample_buffer_if.slave (go, rw, in_valid, z_in, z_out,
//            out_valid, fill, full, wr_done, rd_done, pass_cnt)
//   Build option:
//     ZBUF_WRAP_EN  when defined, READ wraps to entry 0 and streams
//                   indefinitely; otherwise READ parks in HOLD after one pass.
//
//   state | meaning
//   IDLE  | go low; pointer at 0, no output
//   WRITE | capturing z_in on in_valid until fill == DEPTH
//   READ  | streaming stored entries 0..fill-1
//   HOLD  | one pass finished, output quiet until go drops or rw changes
module z_sample_buffer #(
  parameter int unsigned DW    = 26,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned NCH   = 4
) (
  input logic              clk,
  input logic              rst_n,
  z_sample_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned W  = NCH * DW;
  localparam logic [AW:0]   FILL_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [AW:0]    fill_q, fill_d;
  logic [W-1:0]   z_out_q, z_out_d;
  logic           out_valid_q, out_valid_d;
  logic           wr_done_q, wr_done_d;
  logic           rd_done_q, rd_done_d;
  logic [7:0]     pass_q, pass_d;
  logic           mem_we;
  logic           last_entry;

  logic [W-1:0]   mem [DEPTH];

  // Pointer is on the final stored entry of the current pass.
  assign last_entry = ({1'b0, ptr_q} == (fill_q - FILL_ONE));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    z_out_d     = z_out_q;
    out_valid_d = 1'b0;
    wr_done_d   = 1'b0;
    rd_done_d   = 1'b0;
    pass_d      = pass_q;
    mem_we      = 1'b0;

    if (!bus.go) begin
      state_d = IDLE;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ptr_d = '0;
          if (bus.rw) begin
            state_d = WRITE;
            fill_d  = '0;
            pass_d  = '0;
          end else begin
            state_d = READ;
          end
        end

        WRITE: begin
          if (!bus.rw) begin
            // Mode switch: restart at entry 0, no output this cycle.
            state_d = READ;
            ptr_d   = '0;
          end else if (bus.in_valid && (fill_q != FILL_MAX)) begin
            mem_we      = 1'b1;
            ptr_d       = ptr_q + PTR_ONE;
            fill_d      = fill_q + FILL_ONE;
            z_out_d     = bus.z_in;
            out_valid_d = 1'b1;
            wr_done_d   = ((fill_q + FILL_ONE) == FILL_MAX);
          end
        end

        READ: begin
          if (bus.rw) begin
            state_d = WRITE;
            ptr_d   = '0;
            fill_d  = '0;
            pass_d  = '0;
          end else if (fill_q != '0) begin
            z_out_d     = mem[ptr_q];
            out_valid_d = 1'b1;
            if (last_entry) begin
              rd_done_d = 1'b1;
              if (pass_q != 8'hFF) begin
                pass_d = pass_q + 8'd1;
              end
              ptr_d = '0;
`ifdef ZBUF_WRAP_EN
              state_d = READ;
`else
              state_d = HOLD;
`endif
            end else begin
              ptr_d = ptr_q + PTR_ONE;
            end
          end
        end

        HOLD: begin
          if (bus.rw) begin
            state_d = WRITE;
            ptr_d   = '0;
            fill_d  = '0;
            pass_d  = '0;
          end
        end

        default: begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      fill_q      <= '0;
      z_out_q     <= '0;
      out_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      pass_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      z_out_q     <= z_out_d;
      out_valid_q <= out_valid_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
      pass_q      <= pass_d;
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= bus.z_in;
    end
  end

  assign bus.z_out     = z_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fill      = fill_q;
  assign bus.full      = (fill_q == FILL_MAX);
  assign bus.wr_done   = wr_done_q;
  assign bus.rd_done   = rd_done_q;
  assign bus.pass_cnt  = pass_q;
endmodule
